// File: rtl/ex_sig_sync_array.sv
// Per-channel synchronizer, optional glitch filter, registered edge pulses and saturating rise counters.
// Latency SYNC_STAGES+FILT_CNT edges filtered, SYNC_STAGES+1 unfiltered; no backpressure.
module ex_sig_sync_array #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 3,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       sig_in,
  input  logic                      filt_en,
  input  logic                      cnt_clr,
  output logic [CHANNELS-1:0]       sig_out,
  output logic [CHANNELS-1:0]       rise_pulse,
  output logic [CHANNELS-1:0]       fall_pulse,
  output logic [CHANNELS*CNT_W-1:0] rise_cnt
);

  generate
    if (CHANNELS < 1 || CHANNELS > 32 || SYNC_STAGES < 2 || FILT_CNT < 1 || CNT_W < 1) begin : g_param_err
      $error("ex_sig_sync_array: illegal parameter value");
    end
  endgenerate

  localparam int            FW        = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CNT - 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0]                  sync_s;
  logic [CHANNELS-1:0]                  lvl_q, lvl_d;
  logic [CHANNELS-1:0][FW-1:0]          fcnt_q, fcnt_d;
  logic [CHANNELS-1:0]                  rise_q, rise_d;
  logic [CHANNELS-1:0]                  fall_q, fall_d;
  logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q, cnt_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Pure shift chain: nothing combinational between metastability stages.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = sig_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // A new level is accepted only after FILT_CNT consecutive disagreeing samples.
  always_comb begin
    lvl_d  = lvl_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!filt_en) begin
        lvl_d[i]  = sync_s[i];
        fcnt_d[i] = '0;
      end else if (sync_s[i] == lvl_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FILT_LAST) begin
        lvl_d[i]  = sync_s[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + FW'(1);
      end
    end
    rise_d = lvl_d & ~lvl_q;
    fall_d = ~lvl_d & lvl_q;
  end

  // Counter moves on the same edge the pulse is registered, so it reads updated while the pulse is high.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cnt_clr) begin
        cnt_d[i] = '0;
      end else if (rise_d[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_q  <= '0;
      fcnt_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      fcnt_q <= fcnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sig_out    = lvl_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign rise_cnt   = cnt_q;

endmodule

// File: tb/tb_ex_sig_sync_array.sv
// Directed bench: a default-parameter instance and a CNT_W=4 instance driven by the same stimulus.
module tb_ex_sig_sync_array;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sig_in;
  logic        filt_en;
  logic        cnt_clr;
  logic [3:0]  sig_out, rise_pulse, fall_pulse;
  logic [63:0] rise_cnt;
  logic [3:0]  sig_out_w4, rise_pulse_w4, fall_pulse_w4;
  logic [15:0] rise_cnt_w4;

  int checks = 0;
  int errors = 0;

  ex_sig_sync_array dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .filt_en(filt_en), .cnt_clr(cnt_clr),
    .sig_out(sig_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .rise_cnt(rise_cnt)
  );

  ex_sig_sync_array #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .filt_en(filt_en), .cnt_clr(cnt_clr),
    .sig_out(sig_out_w4), .rise_pulse(rise_pulse_w4), .fall_pulse(fall_pulse_w4),
    .rise_cnt(rise_cnt_w4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sin;
    logic        fen;
    logic [3:0]  eout;
    logic [3:0]  erise;
    logic [3:0]  efall;
    logic [63:0] ecnt;
  } vec_t;

  localparam int NV = 50;
  vec_t vecs[NV];

  localparam logic [63:0] C0 = 64'h0000_0000_0000_0000;
  localparam logic [63:0] C1 = 64'h0000_0000_0000_0001;
  localparam logic [63:0] C2 = 64'h0000_0000_0001_0001;
  localparam logic [63:0] C3 = 64'h0000_0001_0001_0001;
  localparam logic [63:0] C4 = 64'h0000_0002_0001_0001;
  localparam logic [63:0] C5 = 64'h0001_0003_0002_0002;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_rows(input int first, input int last, input logic [3:0] sin, input logic fen,
                          input logic [3:0] eout, input logic [3:0] erise, input logic [3:0] efall,
                          input logic [63:0] ecnt);
    for (int r = first; r <= last; r++) begin
      vecs[r].sin   = sin;
      vecs[r].fen   = fen;
      vecs[r].eout  = eout;
      vecs[r].erise = erise;
      vecs[r].efall = efall;
      vecs[r].ecnt  = ecnt;
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eout, input logic [3:0] erise,
                         input logic [3:0] efall, input logic [63:0] ecnt, input logic [15:0] ecnt_w4);
    chk({tag, " sig_out"}, 64'(sig_out), 64'(eout));
    chk({tag, " rise_pulse"}, 64'(rise_pulse), 64'(erise));
    chk({tag, " fall_pulse"}, 64'(fall_pulse), 64'(efall));
    chk({tag, " rise_cnt"}, rise_cnt, ecnt);
    chk({tag, " rise_cnt_w4"}, 64'(rise_cnt_w4), 64'(ecnt_w4));
  endtask

  initial begin
    int npulse;

    // Filtered single rise, 2- and 3-cycle pulses, unfiltered toggling, then all channels together.
    set_rows( 0,  3, 4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0000, C0);
    set_rows( 4,  4, 4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0000, C1);
    set_rows( 5,  5, 4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, C1);
    set_rows( 6,  7, 4'b0011, 1'b1, 4'b0001, 4'b0000, 4'b0000, C1);
    set_rows( 8,  9, 4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, C1);
    set_rows(10, 12, 4'b0011, 1'b1, 4'b0001, 4'b0000, 4'b0000, C1);
    set_rows(13, 13, 4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, C1);
    set_rows(14, 14, 4'b0001, 1'b1, 4'b0011, 4'b0010, 4'b0000, C2);
    set_rows(15, 16, 4'b0001, 1'b1, 4'b0011, 4'b0000, 4'b0000, C2);
    set_rows(17, 17, 4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0010, C2);
    set_rows(18, 19, 4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, C2);
    set_rows(20, 21, 4'b0101, 1'b0, 4'b0001, 4'b0000, 4'b0000, C2);
    set_rows(22, 22, 4'b0101, 1'b0, 4'b0101, 4'b0100, 4'b0000, C3);
    set_rows(23, 23, 4'b0101, 1'b0, 4'b0101, 4'b0000, 4'b0000, C3);
    set_rows(24, 25, 4'b0001, 1'b0, 4'b0101, 4'b0000, 4'b0000, C3);
    set_rows(26, 26, 4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0100, C3);
    set_rows(27, 27, 4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000, C3);
    set_rows(28, 29, 4'b0101, 1'b0, 4'b0001, 4'b0000, 4'b0000, C3);
    set_rows(30, 30, 4'b0101, 1'b0, 4'b0101, 4'b0100, 4'b0000, C4);
    set_rows(31, 31, 4'b0101, 1'b0, 4'b0101, 4'b0000, 4'b0000, C4);
    set_rows(32, 33, 4'b0001, 1'b0, 4'b0101, 4'b0000, 4'b0000, C4);
    set_rows(34, 34, 4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0100, C4);
    set_rows(35, 37, 4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000, C4);
    set_rows(38, 41, 4'b0000, 1'b1, 4'b0001, 4'b0000, 4'b0000, C4);
    set_rows(42, 42, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0001, C4);
    set_rows(43, 43, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, C4);
    set_rows(44, 47, 4'b1111, 1'b1, 4'b0000, 4'b0000, 4'b0000, C4);
    set_rows(48, 48, 4'b1111, 1'b1, 4'b1111, 4'b1111, 4'b0000, C5);
    set_rows(49, 49, 4'b1111, 1'b1, 4'b1111, 4'b0000, 4'b0000, C5);

    rst_n   = 1'b0;
    sig_in  = 4'b0000;
    filt_en = 1'b1;
    cnt_clr = 1'b0;
    tick();
    tick();
    chk_all("reset", 4'b0000, 4'b0000, 4'b0000, C0, 16'h0000);
    rst_n = 1'b1;

    for (int r = 0; r < NV; r++) begin
      sig_in  = vecs[r].sin;
      filt_en = vecs[r].fen;
      tick();
      chk($sformatf("row%0d sig_out", r), 64'(sig_out), 64'(vecs[r].eout));
      chk($sformatf("row%0d rise_pulse", r), 64'(rise_pulse), 64'(vecs[r].erise));
      chk($sformatf("row%0d fall_pulse", r), 64'(fall_pulse), 64'(vecs[r].efall));
      chk($sformatf("row%0d rise_cnt", r), rise_cnt, vecs[r].ecnt);
    end
    chk("table end rise_cnt_w4", 64'(rise_cnt_w4), 64'h1322);

    // 20 unfiltered rises on ch3: the 16-bit counter reaches 21, the 4-bit one sticks at 15.
    filt_en = 1'b0;
    sig_in  = 4'b0111;
    npulse  = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (rise_pulse[3]) npulse++;
    end
    for (int n = 0; n < 20; n++) begin
      sig_in = 4'b1111;
      tick();
      if (rise_pulse[3]) npulse++;
      sig_in = 4'b0111;
      tick();
      if (rise_pulse[3]) npulse++;
    end
    for (int t = 0; t < 4; t++) begin
      tick();
      if (rise_pulse[3]) npulse++;
    end
    chk("sat ch3 rise pulses", 64'(npulse), 64'd20);
    chk_all("sat", 4'b0111, 4'b0000, 4'b0000, 64'h0015_0003_0002_0002, 16'hF322);

    // Clear lands on the same edge as a ch3 rise: the rise is not counted.
    sig_in = 4'b1111;
    tick();
    tick();
    chk("pre-clear rise_cnt_w4", 64'(rise_cnt_w4), 64'hF322);
    cnt_clr = 1'b1;
    tick();
    chk_all("clear edge", 4'b1111, 4'b1000, 4'b0000, C0, 16'h0000);
    cnt_clr = 1'b0;
    tick();
    chk_all("after clear", 4'b1111, 4'b0000, 4'b0000, C0, 16'h0000);

    // Build some state, then reset in the middle of ch0 filtering.
    filt_en = 1'b1;
    sig_in  = 4'b1000;
    for (int t = 0; t < 8; t++) tick();
    chk("drop sig_out", 64'(sig_out), 64'(4'b1000));
    sig_in = 4'b1100;
    for (int t = 0; t < 8; t++) tick();
    chk_all("ch2 up", 4'b1100, 4'b0000, 4'b0000, 64'h0000_0001_0000_0000, 16'h0100);
    sig_in = 4'b1101;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_all("async reset", 4'b0000, 4'b0000, 4'b0000, C0, 16'h0000);
    tick();
    tick();
    chk_all("held reset", 4'b0000, 4'b0000, 4'b0000, C0, 16'h0000);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    chk_all("release +4", 4'b0000, 4'b0000, 4'b0000, C0, 16'h0000);
    tick();
    chk_all("release +5", 4'b1101, 4'b1101, 4'b0000, 64'h0001_0001_0000_0001, 16'h1101);
    tick();
    chk_all("release +6", 4'b1101, 4'b0000, 4'b0000, 64'h0001_0001_0000_0001, 16'h1101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_sig_sync_array.md
EX_SIG_SYNC_ARRAY -- requirements
Module: ex_sig_sync_array

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent external input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flip-flops in each synchronizer chain (minimum 2).
REQ-003 SHALL have parameter FILT_CNT, default 3: consecutive cycles a new level must persist before acceptance (minimum 1).
REQ-004 SHALL have parameter CNT_W, default 16: width of each per-channel rising-edge counter.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port sig_in  input  CHANNELS  asynchronous external signals; bit i is channel i.
REQ-008 SHALL have port filt_en  input  1  synchronous; 1 enables the glitch filter on all channels.
REQ-009 SHALL have port cnt_clr  input  1  synchronous; 1 clears all edge counters.
REQ-010 SHALL have port sig_out  output  CHANNELS  synchronized, optionally filtered level per channel.
REQ-011 SHALL have port rise_pulse  output  CHANNELS  one-cycle pulse per accepted 0->1 transition.
REQ-012 SHALL have port fall_pulse  output  CHANNELS  one-cycle pulse per accepted 1->0 transition.
REQ-013 SHALL have port rise_cnt  output  CHANNELS*CNT_W  packed counters; channel i occupies bits [i*CNT_W +: CNT_W].

Function
REQ-014 SHALL pass each sig_in bit through its own SYNC_STAGES-deep flip-flop chain; the last stage is the synchronized level s[i]; no logic between chain stages.
REQ-015 SHALL keep per channel an accepted level q[i] (driving sig_out[i]) and a filter counter wide enough to hold FILT_CNT-1.
REQ-016 With filt_en=1: counter increments on each edge where s[i]!=q[i]; on the FILT_CNT-th consecutive such edge q[i]<=s[i] and counter<=0; any edge with s[i]==q[i] clears counter.
REQ-017 With filt_en=0: q[i]<=s[i] on every edge and counter held at 0 (filter disabled, equivalent to FILT_CNT=1).
REQ-018 SHALL clear all filter counters on the first edge where filt_en=0; a filt_en change takes effect on the next edge and causes no spurious pulse.
REQ-019 Latency from an input change settling before edge 1 to sig_out change: SYNC_STAGES+FILT_CNT edges when filtered, SYNC_STAGES+1 edges when unfiltered.
REQ-020 A pulse shorter than FILT_CNT cycles at s[i] with filt_en=1 SHALL NOT change sig_out, pulse, or counter.
REQ-021 rise_pulse[i] SHALL be registered and high for exactly the one cycle in which sig_out[i] first reads 1 after reading 0; fall_pulse[i] likewise for 1->0.
REQ-022 rise_cnt channel i SHALL increment by 1 in the cycle rise_pulse[i] is high, saturating at 2^CNT_W-1 (no wrap).
REQ-023 cnt_clr=1 SHALL set all counters to 0 on that edge; clear has priority over a simultaneous increment (that edge is not counted).
REQ-024 Channels SHALL be fully independent; simultaneous transitions on any set of channels are all processed in the same cycle.
REQ-025 SYNC_STAGES<2, FILT_CNT<1, CNT_W<1 or CHANNELS outside 1..32 SHALL cause an elaboration error.

Reset
REQ-026 rst_n low SHALL asynchronously clear all sync stages, q, filter counters, rise_pulse, fall_pulse and rise_cnt to 0; sig_out reads 0.
REQ-027 Reset release SHALL be sampled synchronously; an input held high through reset produces one rise_pulse after SYNC_STAGES+FILT_CNT edges (treated as 0->1).
REQ-028 Reset asserted mid-filter or mid-pulse SHALL abort it; no pulse or count survives reset.

Verification
REQ-029 Defaults, filt_en=1, sig_in[0] 0->1 held: sig_out[0] rises on edge 5 after change, rise_pulse[0] high one cycle, rise_cnt ch0=1, other channels unchanged.
REQ-030 filt_en=1, sig_in[1] high for 2 cycles then low: sig_out[1], pulses, rise_cnt ch1 stay 0; repeat with 3-cycle pulse: one rise and one fall pulse, count=1.
REQ-031 filt_en=0, sig_in[2] toggled every 4 cycles: sig_out[2] follows with 3-edge latency, every transition yields one pulse, count increments per rise.
REQ-032 CNT_W=4, 20 accepted rises on ch3: rise_cnt ch3 saturates at 15; then cnt_clr coincident with a rise: count reads 0 next cycle.
REQ-033 All four channels rise same cycle: all sig_out, rise_pulse bits, counters update on identical edge.
REQ-034 rst_n pulsed low while ch0 filter counter=1 and sig_in[0] high: outputs 0 immediately; after release sig_out[0] rises 5 edges later with one rise_pulse.
